// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_EOT,
    GAP
  } uart_arb_state_t;

endpackage

// File: rtl/uart_arb_pick.sv
// Combinational winner selection for uart_tx_arbiter; one-hot result.
// UART_TX_ARB_RR_EN selects round-robin from ptr_i, otherwise fixed lowest-index priority.
module uart_arb_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
`ifdef UART_TX_ARB_RR_EN
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [$clog2(N_REQ)-1:0] next_ptr_o,
`endif
  output logic [N_REQ-1:0]         win_o
);

`ifdef UART_TX_ARB_RR_EN
  localparam int PTR_W = $clog2(N_REQ);

  logic                 found;
  logic [PTR_W-1:0]     idx;

  // Scan starts at the slot after the previous winner and wraps.
  always_comb begin
    win_o      = '0;
    next_ptr_o = ptr_i;
    found      = 1'b0;
    idx        = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = PTR_W'((32'(ptr_i) + off) % N_REQ);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        win_o[idx] = 1'b1;
        next_ptr_o = PTR_W'((32'(idx) + 32'd1) % N_REQ);
      end
    end
  end
`else
  logic found;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_i[i]) begin
        found    = 1'b1;
        win_o[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among N_REQ byte producers: arbitrate, latch, Start, track EOT, gap.
// Build option: UART_TX_ARB_RR_EN enables round-robin arbitration (default fixed priority).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic [N_REQ-1:0]             Req,
  input  logic [UART_DATA_W*N_REQ-1:0] Data,
  output logic [N_REQ-1:0]             Ack,
  output logic [N_REQ-1:0]             Done,
  output logic [N_REQ-1:0]             Grant,
  output logic                         Busy,
  output logic [UART_DATA_W-1:0]       Tx_Data,
  output logic                         Tx_Start,
  input  logic                         Tx_EOT
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  uart_arb_state_t        state_q, state_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic [N_REQ-1:0]       ack_q, ack_d;
  logic [N_REQ-1:0]       done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   start_q, start_d;
  logic [UART_DATA_W-1:0] txd_q, txd_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [N_REQ-1:0]       win;
  logic [UART_DATA_W-1:0] win_byte;

`ifdef UART_TX_ARB_RR_EN
  logic [$clog2(N_REQ)-1:0] ptr_q, ptr_d, next_ptr;
`endif

  uart_arb_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i      (Req),
`ifdef UART_TX_ARB_RR_EN
    .ptr_i      (ptr_q),
    .next_ptr_o (next_ptr),
`endif
    .win_o      (win)
  );

  always_comb begin
    win_byte = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win[i]) win_byte = Data[UART_DATA_W*i +: UART_DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    done_d  = '0;
    busy_d  = busy_q;
    start_d = 1'b0;
    txd_d   = txd_q;
    gap_d   = gap_q;
`ifdef UART_TX_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|Req && Tx_EOT) begin
          grant_d = win;
          ack_d   = win;
          txd_d   = win_byte;
          busy_d  = 1'b1;
`ifdef UART_TX_ARB_RR_EN
          ptr_d   = next_ptr;
`endif
          state_d = START;
        end
      end
      START: begin
        start_d = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!Tx_EOT) state_d = WAIT_EOT;
      end
      WAIT_EOT: begin
        if (Tx_EOT) begin
          done_d  = grant_q;
          grant_d = '0;
          if (GAP_CYCLES == 0) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            // The Done cycle itself is the first gap cycle.
            gap_d   = GAP_W'(GAP_CYCLES - 1);
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      txd_q   <= '0;
      gap_q   <= '0;
`ifdef UART_TX_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      txd_q   <= txd_d;
      gap_q   <= gap_d;
`ifdef UART_TX_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign Ack      = ack_q;
  assign Done     = done_q;
  assign Grant    = grant_q;
  assign Busy     = busy_q;
  assign Tx_Data  = txd_q;
  assign Tx_Start = start_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural EOT model (EOT low BYTE_T cycles after Start).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N      = 4;
  localparam int GAP    = 16;
  localparam int BYTE_T = 20;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [8*N-1:0] data  = '0;
  logic [N-1:0]   ack, done, grant;
  logic           busy, tx_start, eot;
  logic [7:0]     tx_data;

  logic [N-1:0]   req0  = '0;
  logic [8*N-1:0] data0 = '0;
  logic [N-1:0]   ack0, done0, grant0;
  logic           busy0, tx_start0, eot0;
  logic [7:0]     tx_data0;

  int eot_cnt, eot_cnt0;
  int n_vec = 0, n_err = 0;
  int cyc = 0, ack_cnt = 0, done_cnt = 0, multi = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP)) u_dut (
    .Clk(clk), .Rst_n(rst_n), .Req(req), .Data(data), .Ack(ack), .Done(done),
    .Grant(grant), .Busy(busy), .Tx_Data(tx_data), .Tx_Start(tx_start), .Tx_EOT(eot)
  );

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(0)) u_dut_gap0 (
    .Clk(clk), .Rst_n(rst_n), .Req(req0), .Data(data0), .Ack(ack0), .Done(done0),
    .Grant(grant0), .Busy(busy0), .Tx_Data(tx_data0), .Tx_Start(tx_start0), .Tx_EOT(eot0)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eot <= 1'b1; eot_cnt <= 0;
    end else if (tx_start) begin
      eot <= 1'b0; eot_cnt <= BYTE_T;
    end else if (eot_cnt == 1) begin
      eot <= 1'b1; eot_cnt <= 0;
    end else if (eot_cnt > 1) begin
      eot_cnt <= eot_cnt - 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eot0 <= 1'b1; eot_cnt0 <= 0;
    end else if (tx_start0) begin
      eot0 <= 1'b0; eot_cnt0 <= BYTE_T;
    end else if (eot_cnt0 == 1) begin
      eot0 <= 1'b1; eot_cnt0 <= 0;
    end else if (eot_cnt0 > 1) begin
      eot_cnt0 <= eot_cnt0 - 1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ack != '0) ack_cnt++;
    if (done != '0) done_cnt++;
    if ($countones(ack) > 1 || $countones(done) > 1 ||
        $countones(ack0) > 1 || $countones(done0) > 1) multi++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 = ack, 1 = done, 2 = busy low, 3 = ack0, 4 = done0; lat = -1 on timeout
  task automatic wait_for(input int which, input int budget, output int lat);
    bit hit;
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = (ack != '0);
        1:       hit = (done != '0);
        2:       hit = !busy;
        3:       hit = (ack0 != '0);
        default: hit = (done0 != '0);
      endcase
      if (hit) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; data = '0; req0 = '0; data0 = '0;
    tick(3);
    n_vec++; if (grant !== '0) begin n_err++; $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000); end
    n_vec++; if (ack !== '0 || done !== '0) begin n_err++; $display("FAIL reset_ack_done: got ack=%b done=%b expected 0000/0000", ack, done); end
    n_vec++; if (busy !== 1'b0 || tx_start !== 1'b0) begin n_err++; $display("FAIL reset_busy_start: got busy=%b start=%b expected 0/0", busy, tx_start); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    n_vec++; if (grant0 !== '0 || busy0 !== 1'b0) begin n_err++; $display("FAIL reset_gap0: got grant=%b busy=%b expected 0000/0", grant0, busy0); end
    rst_n = 1'b1;
    tick(2);
    n_vec++; if (busy !== 1'b0 || ack !== '0) begin n_err++; $display("FAIL idle_no_req: got busy=%b ack=%b expected 0/0000", busy, ack); end
  endtask

  task automatic test_single();
    int lat;
    data[7:0] = 8'hAA; req = 4'b0001;
    wait_for(0, 5, lat);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL single_ack_latency: got %0d expected 1", lat); end
    n_vec++; if (ack !== 4'b0001 || grant !== 4'b0001) begin n_err++; $display("FAIL single_ack_grant: got ack=%b grant=%b expected 0001/0001", ack, grant); end
    n_vec++; if (tx_data !== 8'hAA || busy !== 1'b1 || tx_start !== 1'b0) begin n_err++; $display("FAIL single_latch: got data=%h busy=%b start=%b expected AA/1/0", tx_data, busy, tx_start); end
    req = '0;
    tick(1);
    n_vec++; if (tx_start !== 1'b1 || ack !== '0) begin n_err++; $display("FAIL single_start: got start=%b ack=%b expected 1/0000", tx_start, ack); end
    tick(1);
    n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL single_start_pulse: got %b expected 0", tx_start); end
    wait_for(1, 60, lat);
    n_vec++; if (lat !== BYTE_T + 1) begin n_err++; $display("FAIL single_done_latency: got %0d expected %0d", lat, BYTE_T + 1); end
    n_vec++; if (done !== 4'b0001 || grant !== '0 || eot !== 1'b1) begin n_err++; $display("FAIL single_done: got done=%b grant=%b eot=%b expected 0001/0000/1", done, grant, eot); end
    tick(1);
    n_vec++; if (done !== '0) begin n_err++; $display("FAIL single_done_pulse: got %b expected 0000", done); end
    tick(14);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_gap_busy: got %b expected 1", busy); end
    tick(1);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_gap_end: got %b expected 0", busy); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_b [4];
    int lat, prev, a0, d0;
    exp_b[0] = 8'h03; exp_b[1] = 8'hCC; exp_b[2] = 8'h55; exp_b[3] = 8'hF0;
    a0 = ack_cnt; d0 = done_cnt; prev = 0;
    data = {8'hF0, 8'h55, 8'hCC, 8'h03}; req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_for(0, 100, lat);
      n_vec++; if (ack !== 4'(1 << k) || tx_data !== exp_b[k]) begin n_err++; $display("FAIL simul_order_%0d: got ack=%b data=%h expected %b/%h", k, ack, tx_data, 4'(1 << k), exp_b[k]); end
      req[k] = 1'b0;
      tick(1);
      n_vec++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL simul_start_%0d: got %b expected 1", k, tx_start); end
      if (k > 0) begin
        n_vec++; if (cyc - prev !== BYTE_T + GAP + 4) begin n_err++; $display("FAIL simul_spacing_%0d: got %0d expected %0d", k, cyc - prev, BYTE_T + GAP + 4); end
      end
      prev = cyc;
    end
    wait_for(2, 100, lat);
    n_vec++; if (ack_cnt - a0 !== 4 || done_cnt - d0 !== 4) begin n_err++; $display("FAIL simul_counts: got acks=%0d dones=%0d expected 4/4", ack_cnt - a0, done_cnt - d0); end
    n_vec++; if (multi !== 0) begin n_err++; $display("FAIL simul_onehot: got %0d multi-hot cycles expected 0", multi); end
  endtask

  task automatic test_fairness();
    int lat;
    logic [N-1:0] exp2, exp3;
`ifdef UART_TX_ARB_RR_EN
    exp2 = 4'b0100; exp3 = 4'b0001;
`else
    exp2 = 4'b0001; exp3 = 4'b0100;
`endif
    data = '0; data[7:0] = 8'h11; data[23:16] = 8'h22; req = 4'b0101;
    wait_for(0, 100, lat);
    n_vec++; if (ack !== 4'b0001) begin n_err++; $display("FAIL fair_first: got %b expected 0001", ack); end
    wait_for(0, 100, lat);
    n_vec++; if (ack !== exp2 || lat !== BYTE_T + GAP + 4) begin n_err++; $display("FAIL fair_second: got ack=%b lat=%0d expected %b/%0d", ack, lat, exp2, BYTE_T + GAP + 4); end
    req = req & ~ack;
    wait_for(0, 100, lat);
    n_vec++; if (ack !== exp3) begin n_err++; $display("FAIL fair_third: got %b expected %b", ack, exp3); end
    req = '0;
    wait_for(2, 100, lat);
  endtask

  task automatic test_late();
    int lat, bad;
    data[31:24] = 8'h3C; req = 4'b1000;
    wait_for(0, 10, lat);
    n_vec++; if (ack !== 4'b1000) begin n_err++; $display("FAIL late_first_ack: got %b expected 1000", ack); end
    req = '0;
    tick(8);
    data[15:8] = 8'h96; req = 4'b0010;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done != '0) break;
      if (ack != '0 || tx_data != 8'h3C) bad++;
    end
    n_vec++; if (done !== 4'b1000) begin n_err++; $display("FAIL late_done: got %b expected 1000", done); end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL late_hold: got %0d bad cycles expected 0", bad); end
    bad = 0;
    for (int i = 0; i < GAP; i++) begin
      @(negedge clk);
      if (ack != '0) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL late_gap_noack: got %0d acks expected 0", bad); end
    tick(1);
    n_vec++; if (ack !== 4'b0010 || tx_data !== 8'h96) begin n_err++; $display("FAIL late_served: got ack=%b data=%h expected 0010/96", ack, tx_data); end
    req = '0;
    wait_for(2, 100, lat);
  endtask

  task automatic test_reset_mid();
    int lat, d0;
    data[23:16] = 8'h5A; req = 4'b0100;
    wait_for(0, 10, lat);
    n_vec++; if (ack !== 4'b0100) begin n_err++; $display("FAIL rmid_ack: got %b expected 0100", ack); end
    req = '0;
    data[15:8] = 8'h77; req = 4'b0010;
    tick(8);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (grant !== '0 || busy !== 1'b0 || tx_data !== 8'h00 || ack !== '0 || tx_start !== 1'b0) begin n_err++; $display("FAIL rmid_async: got grant=%b busy=%b data=%h ack=%b start=%b expected all zero", grant, busy, tx_data, ack, tx_start); end
    tick(10);
    rst_n = 1'b1;
    n_vec++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL rmid_no_done: got %0d done pulses expected 0", done_cnt - d0); end
    wait_for(0, 5, lat);
    n_vec++; if (lat !== 1 || ack !== 4'b0010 || tx_data !== 8'h77) begin n_err++; $display("FAIL rmid_reserve: got lat=%0d ack=%b data=%h expected 1/0010/77", lat, ack, tx_data); end
    req = '0;
    wait_for(2, 100, lat);
  endtask

  task automatic test_gap0();
    int lat;
    data0 = '0; data0[7:0] = 8'h11; data0[15:8] = 8'h22; req0 = 4'b0011;
    wait_for(3, 10, lat);
    n_vec++; if (ack0 !== 4'b0001 || tx_data0 !== 8'h11) begin n_err++; $display("FAIL gap0_first: got ack=%b data=%h expected 0001/11", ack0, tx_data0); end
    req0[0] = 1'b0;
    wait_for(4, 60, lat);
    n_vec++; if (done0 !== 4'b0001 || busy0 !== 1'b0 || grant0 !== '0) begin n_err++; $display("FAIL gap0_done_idle: got done=%b busy=%b grant=%b expected 0001/0/0000", done0, busy0, grant0); end
    tick(1);
    n_vec++; if (ack0 !== 4'b0010 || tx_data0 !== 8'h22) begin n_err++; $display("FAIL gap0_next_ack: got ack=%b data=%h expected 0010/22", ack0, tx_data0); end
    req0 = '0;
    tick(1);
    n_vec++; if (tx_start0 !== 1'b1) begin n_err++; $display("FAIL gap0_next_start: got %b expected 1", tx_start0); end
    tick(30);
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_late();
    test_reset_mid();
    test_gap0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
